// File: rtl/adf4030_trig_scheduler_if.sv
// Control/status bundle between the register map and the trigger scheduler.
// Master drives the controls and BSYNC; slave (the scheduler) drives trigger outputs and status.
interface adf4030_trig_scheduler_if #(
    parameter int CHANNEL_COUNT = 8,
    parameter int PHASE_WIDTH   = 16,
    parameter int BURST_WIDTH   = 8
);
    logic                               bsync;
    logic [CHANNEL_COUNT-1:0]           ch_enable;
    logic [2*CHANNEL_COUNT-1:0]         ch_mode;
    logic [PHASE_WIDTH*CHANNEL_COUNT-1:0] ch_phase;
    logic [BURST_WIDTH*CHANNEL_COUNT-1:0] ch_burst_len;
    logic [CHANNEL_COUNT-1:0]           ch_arm;
    logic [CHANNEL_COUNT-1:0]           clear_overrun;
    logic [CHANNEL_COUNT-1:0]           trig_out;
    logic [CHANNEL_COUNT-1:0]           ch_busy;
    logic [3*CHANNEL_COUNT-1:0]         ch_state;
    logic [CHANNEL_COUNT-1:0]           ch_overrun;

    modport master (
        output bsync, ch_enable, ch_mode, ch_phase, ch_burst_len, ch_arm, clear_overrun,
        input  trig_out, ch_busy, ch_state, ch_overrun
    );

    modport slave (
        input  bsync, ch_enable, ch_mode, ch_phase, ch_burst_len, ch_arm, clear_overrun,
        output trig_out, ch_busy, ch_state, ch_overrun
    );
endinterface

// File: rtl/adf4030_trig_scheduler.sv
// Per-channel BSYNC-aligned trigger scheduler (continuous/one-shot/burst); trig_out rises phase+1 cycles after BSYNC.
// No backpressure: a BSYNC that lands while a channel is in DELAY/FIRE is dropped and flagged as sticky overrun.
module adf4030_trig_scheduler #(
    parameter int CHANNEL_COUNT = 8,
    parameter int PHASE_WIDTH   = 16,
    parameter int BURST_WIDTH   = 8,
    parameter int PULSE_WIDTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    adf4030_trig_scheduler_if.slave     bus
);
    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_FIRE  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_CONT  = 2'b00;
    localparam logic [1:0] M_ONE   = 2'b01;
    localparam logic [1:0] M_BURST = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;

    logic [2:0]             state_q [CHANNEL_COUNT];
    logic [2:0]             state_d [CHANNEL_COUNT];
    logic [1:0]             mode_q  [CHANNEL_COUNT];
    logic [1:0]             mode_d  [CHANNEL_COUNT];
    logic [PHASE_WIDTH-1:0] dcnt_q  [CHANNEL_COUNT];
    logic [PHASE_WIDTH-1:0] dcnt_d  [CHANNEL_COUNT];
    logic [PCW-1:0]         pcnt_q  [CHANNEL_COUNT];
    logic [PCW-1:0]         pcnt_d  [CHANNEL_COUNT];
    logic [BURST_WIDTH-1:0] rem_q   [CHANNEL_COUNT];
    logic [BURST_WIDTH-1:0] rem_d   [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] trig_q, trig_d;
    logic [CHANNEL_COUNT-1:0] busy_q, busy_d;
    logic [CHANNEL_COUNT-1:0] ovr_q,  ovr_d;

    function automatic logic [BURST_WIDTH-1:0] burst_load(input logic [BURST_WIDTH-1:0] len);
        return (len == '0) ? BURST_WIDTH'(1) : len;
    endfunction

    always_comb begin
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            state_d[i] = state_q[i];
            mode_d[i]  = mode_q[i];
            dcnt_d[i]  = dcnt_q[i];
            pcnt_d[i]  = pcnt_q[i];
            rem_d[i]   = rem_q[i];

            // Set beats clear: a BSYNC seen while busy always leaves the flag high.
            ovr_d[i] = (bus.bsync && (state_q[i] == S_DELAY || state_q[i] == S_FIRE))
                     || (ovr_q[i] && !bus.clear_overrun[i]);

            if (!bus.ch_enable[i]) begin
                state_d[i] = S_IDLE;
                rem_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_IDLE, S_DONE: begin
                        if (state_q[i] == S_IDLE && bus.ch_mode[2*i +: 2] == M_CONT) begin
                            state_d[i] = S_ARMED;
                            mode_d[i]  = M_CONT;
                        end else if (bus.ch_arm[i] && bus.ch_mode[2*i +: 2] != M_RSVD) begin
                            state_d[i] = S_ARMED;
                            mode_d[i]  = bus.ch_mode[2*i +: 2];
                            rem_d[i]   = burst_load(bus.ch_burst_len[BURST_WIDTH*i +: BURST_WIDTH]);
                        end
                    end
                    S_ARMED: begin
                        if (bus.bsync) begin
                            state_d[i] = S_DELAY;
                            dcnt_d[i]  = bus.ch_phase[PHASE_WIDTH*i +: PHASE_WIDTH];
                        end
                    end
                    S_DELAY: begin
                        if (dcnt_q[i] == '0) begin
                            state_d[i] = S_FIRE;
                            pcnt_d[i]  = PCW'(PULSE_WIDTH - 1);
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - PHASE_WIDTH'(1);
                        end
                    end
                    S_FIRE: begin
                        if (pcnt_q[i] != '0) begin
                            pcnt_d[i] = pcnt_q[i] - PCW'(1);
                        end else begin
                            case (mode_q[i])
                                M_CONT:  state_d[i] = S_ARMED;
                                M_ONE:   state_d[i] = S_DONE;
                                M_BURST: begin
                                    rem_d[i]   = rem_q[i] - BURST_WIDTH'(1);
                                    state_d[i] = (rem_q[i] > BURST_WIDTH'(1)) ? S_ARMED : S_DONE;
                                end
                                default: state_d[i] = S_DONE;
                            endcase
                        end
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end

            trig_d[i] = (state_d[i] == S_FIRE);
            busy_d[i] = (state_d[i] == S_DELAY) || (state_d[i] == S_FIRE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                state_q[i] <= S_IDLE;
                mode_q[i]  <= M_CONT;
                dcnt_q[i]  <= '0;
                pcnt_q[i]  <= '0;
                rem_q[i]   <= '0;
            end
            trig_q <= '0;
            busy_q <= '0;
            ovr_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dcnt_q  <= dcnt_d;
            pcnt_q  <= pcnt_d;
            rem_q   <= rem_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        bus.ch_state = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            bus.ch_state[3*i +: 3] = state_q[i];
        end
    end

    assign bus.trig_out   = trig_q;
    assign bus.ch_busy    = busy_q;
    assign bus.ch_overrun = ovr_q;
endmodule
